// File: rtl/remote_pkg.sv
// remote_pkg: shared types and constants for the host-side UART command link.
//   state_t     - main FSM states (IDLE, TX_HI, TX_LO, WAIT_RESP)
//   rx_state_t  - receiver states
//   RESP_DONE / RESP_PROG - robot response codes
//   FRAME_BITS  - 8N1 frame length (start + 8 data + stop)
//   frame_of()  - builds an LSB-first 8N1 frame for one byte
package remote_pkg;

  typedef enum logic [1:0] {IDLE, TX_HI, TX_LO, WAIT_RESP} state_t;
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;

  localparam logic [7:0] RESP_DONE  = 8'hA5;
  localparam logic [7:0] RESP_PROG  = 8'h5A;
  localparam int         FRAME_BITS = 10;
  localparam logic [3:0] LAST_BIT   = 4'(FRAME_BITS - 1);

  // Bit 0 is the first bit on the wire: start(0), data LSB-first, stop(1).
  function automatic logic [FRAME_BITS-1:0] frame_of(input logic [7:0] b);
    return {1'b1, b, 1'b0};
  endfunction

endpackage

// File: rtl/uart_byte_rx.sv
// uart_byte_rx: 8N1 byte receiver for the robot's response line.
//   clk, rst      - clock, synchronous active-high reset
//   rx            - asynchronous serial input (idles high)
//   resp          - last validly framed byte, held until the next one
//   resp_rdy      - one-cycle pulse per valid byte (coincident with resp update)
//   frm_err       - one-cycle pulse when the stop bit samples 0
//   byte_stb      - combinational: valid stop sample this cycle
//   byte_nxt      - combinational: the byte being completed by byte_stb
// byte_stb/byte_nxt let the host FSM react on the same edge that loads resp.
module uart_byte_rx
  import remote_pkg::*;
#(
  parameter int BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] resp,
  output logic       resp_rdy,
  output logic       frm_err,
  output logic       byte_stb,
  output logic [7:0] byte_nxt
);

  localparam logic [11:0] HALF = 12'(BAUD_DIV / 2 - 1);
  localparam logic [11:0] LAST = 12'(BAUD_DIV - 1);

  logic        rx_m, rx_s, rx_d;   // sync stages + previous synced value
  rx_state_t   rstate;
  logic [11:0] cnt;
  logic [3:0]  nbit;
  logic [7:0]  sh;
  logic        samp_stop;

  assign samp_stop = (rstate == R_STOP) && (cnt == LAST);
  assign byte_stb  = samp_stop && rx_s;
  assign byte_nxt  = sh;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m     <= 1'b1;
      rx_s     <= 1'b1;
      rx_d     <= 1'b1;
      rstate   <= R_IDLE;
      cnt      <= '0;
      nbit     <= '0;
      sh       <= '0;
      resp     <= '0;
      resp_rdy <= 1'b0;
      frm_err  <= 1'b0;
    end else begin
      rx_m     <= rx;
      rx_s     <= rx_m;
      rx_d     <= rx_s;
      resp_rdy <= byte_stb;
      frm_err  <= samp_stop && !rx_s;
      if (byte_stb) resp <= sh;

      unique case (rstate)
        R_IDLE: begin
          cnt <= '0;
          if (rx_d && !rx_s) rstate <= R_START;
        end
        R_START: begin
          // Mid-start re-check: a line already back high was a glitch.
          if (cnt == HALF) begin
            cnt    <= '0;
            nbit   <= '0;
            rstate <= rx_s ? R_IDLE : R_DATA;
          end else begin
            cnt <= cnt + 12'd1;
          end
        end
        R_DATA: begin
          if (cnt == LAST) begin
            cnt  <= '0;
            sh   <= {rx_s, sh[7:1]};
            nbit <= nbit + 4'd1;
            if (nbit == 4'd7) rstate <= R_STOP;
          end else begin
            cnt <= cnt + 12'd1;
          end
        end
        R_STOP: begin
          // Re-arm right after the stop sample so back-to-back frames work.
          if (cnt == LAST) begin
            cnt    <= '0;
            rstate <= R_IDLE;
          end else begin
            cnt <= cnt + 12'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/remote_cmd_tx.sv
// remote_cmd_tx: host-side UART command sender for the robot link.
//   clk, rst  - clock, synchronous active-high reset
//   cmd       - 16-bit command, captured when snd_cmd is accepted (busy=0)
//   snd_cmd   - send request; ignored while busy
//   RX / TX   - serial in from robot / serial out to robot (TX idles high)
//   busy      - accepted command not yet completed
//   cmd_sent  - pulse in the last cycle of the low byte's stop bit
//   resp_rdy, resp, frm_err - receiver outputs (see uart_byte_rx)
//   timeout   - pulse when no 0xA5 arrives within RESP_TIMEOUT cycles
// Optional macro REMOTE_TIMEOUT_EN builds the response timeout counter;
// without it WAIT_RESP waits for 0xA5 indefinitely and timeout stays 0.
module remote_cmd_tx
  import remote_pkg::*;
#(
  parameter int BAUD_DIV     = 2604,
  parameter int RESP_TIMEOUT = 50_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cmd,
  input  logic        snd_cmd,
  input  logic        RX,
  output logic        TX,
  output logic        busy,
  output logic        cmd_sent,
  output logic        resp_rdy,
  output logic [7:0]  resp,
  output logic        frm_err,
  output logic        timeout
);

  localparam logic [11:0] BAUD_LAST = 12'(BAUD_DIV - 1);
  localparam logic [11:0] BAUD_PRE  = 12'(BAUD_DIV - 2);

  state_t                state;
  logic [15:0]           shadow;
  logic [11:0]           baud_cnt;
  logic [3:0]            bit_cnt;
  logic [FRAME_BITS-1:0] tx_sh;     // tx_sh[0] is the bit on the wire
  logic                  busy_q, cmd_sent_q, timeout_q;
  logic                  byte_stb;
  logic [7:0]            byte_nxt;
  logic                  done_hit, bit_end, to_hit;
  logic [FRAME_BITS-1:0] hi_frame, lo_frame;

  assign hi_frame = frame_of(cmd[15:8]);
  assign lo_frame = frame_of(shadow[7:0]);
  assign done_hit = byte_stb && (byte_nxt == RESP_DONE);
  assign bit_end  = (baud_cnt == BAUD_LAST);

  assign TX       = tx_sh[0];
  assign busy     = busy_q;
  assign cmd_sent = cmd_sent_q;
  assign timeout  = timeout_q;

`ifdef REMOTE_TIMEOUT_EN
  logic [25:0] to_cnt;

  // Counter is 0 in the first WAIT_RESP cycle. Expiry fires on the edge
  // where it steps to RESP_TIMEOUT-1 so the registered pulse lines up with it.
  assign to_hit = (state == WAIT_RESP) && (to_cnt == 26'(RESP_TIMEOUT - 2));

  always_ff @(posedge clk) begin
    if (rst || state != WAIT_RESP) to_cnt <= '0;
    else                           to_cnt <= to_cnt + 26'd1;
  end
`else
  assign to_hit = 1'b0;
`endif

  uart_byte_rx #(.BAUD_DIV(BAUD_DIV)) u_rx (
    .clk      (clk),
    .rst      (rst),
    .rx       (RX),
    .resp     (resp),
    .resp_rdy (resp_rdy),
    .frm_err  (frm_err),
    .byte_stb (byte_stb),
    .byte_nxt (byte_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      shadow     <= '0;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      tx_sh      <= '1;
      busy_q     <= 1'b0;
      cmd_sent_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      cmd_sent_q <= 1'b0;
      timeout_q  <= 1'b0;

      unique case (state)
        IDLE: begin
          if (snd_cmd) begin
            shadow   <= cmd;
            busy_q   <= 1'b1;
            tx_sh    <= hi_frame;   // start bit appears next cycle
            baud_cnt <= '0;
            bit_cnt  <= '0;
            state    <= TX_HI;
          end
        end
        TX_HI, TX_LO: begin
          baud_cnt <= bit_end ? '0 : baud_cnt + 12'd1;
          // Set one cycle early so the pulse sits in the stop bit's last cycle.
          if (state == TX_LO && bit_cnt == LAST_BIT && baud_cnt == BAUD_PRE)
            cmd_sent_q <= 1'b1;
          if (bit_end) begin
            if (bit_cnt == LAST_BIT) begin
              bit_cnt <= '0;
              if (state == TX_HI) begin
                tx_sh <= lo_frame;  // no idle gap between frames
                state <= TX_LO;
              end else begin
                tx_sh <= '1;
                state <= WAIT_RESP;
              end
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
              tx_sh   <= {1'b1, tx_sh[FRAME_BITS-1:1]};
            end
          end
        end
        WAIT_RESP: begin
          // 0xA5 takes priority over a coincident timeout.
          if (done_hit) begin
            busy_q <= 1'b0;
            state  <= IDLE;
          end else if (to_hit) begin
            timeout_q <= 1'b1;
            busy_q    <= 1'b0;
            state     <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_remote_cmd_tx.sv
module tb_remote_cmd_tx;
  import remote_pkg::*;

  localparam int BD = 16;
  localparam int TO = 1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        snd_cmd = 1'b0;
  logic        RX = 1'b1;
  logic [15:0] cmd = '0;
  logic        TX, busy, cmd_sent, resp_rdy, frm_err, timeout;
  logic [7:0]  resp;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  remote_cmd_tx #(.BAUD_DIV(BD), .RESP_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .cmd(cmd), .snd_cmd(snd_cmd), .RX(RX), .TX(TX),
    .busy(busy), .cmd_sent(cmd_sent), .resp_rdy(resp_rdy), .resp(resp),
    .frm_err(frm_err), .timeout(timeout)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // ---- monitor (samples on the falling edge) ----
  logic [7:0] rq[$];
  int   fe_n = 0, to_n = 0, cs_cyc = 0, to_cyc = 0;
  logic busy_prev = 1'b0, a5_busy = 1'b1, a5_prev = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      if (resp_rdy) begin
        rq.push_back(resp);
        if (resp == RESP_DONE) begin
          a5_busy = busy;
          a5_prev = busy_prev;
        end
      end
      if (frm_err)  fe_n++;
      if (cmd_sent) cs_cyc = cyc;
      if (timeout) begin
        to_n++;
        to_cyc = cyc;
      end
    end
    busy_prev = busy;
  end

  // ---- reference model: wire bit k (0..19) of a command ----
  function automatic logic model_tx(input logic [15:0] c, input int k);
    int f = k / 10;
    int p = k % 10;
    logic [7:0] b = (f == 0) ? c[15:8] : c[7:0];
    if (p == 0) return 1'b0;
    if (p == 9) return 1'b1;
    return b[p-1];
  endfunction

  // Issue a command and check the 320-cycle transmission against the model.
  // poke=1 also raises snd_cmd with 0xFFFF mid-frame, which must be ignored.
  task automatic do_cmd(input logic [15:0] c, input bit poke);
    logic [19:0] expw, obs;
    int nmis, cs_pos, cs_hits, busy_low, w;
    expw = '0; obs = '0; nmis = 0; cs_pos = -1; cs_hits = 0; busy_low = 0; w = 0;
    for (int k = 0; k < 20; k++) expw[k] = model_tx(c, k);
    cmd = c; snd_cmd = 1'b1;
    @(negedge clk);
    snd_cmd = 1'b0;
    while (TX !== 1'b0 && w < 10) begin @(negedge clk); w++; end
    chk("tx_start", 32'(TX === 1'b0), 1);
    if (TX !== 1'b0) return;
    // Sample i = cycle i+1 of the frame (first low cycle is i=0).
    for (int i = 0; i < 20 * BD; i++) begin
      if (TX !== model_tx(c, i / BD)) nmis++;
      if (i % BD == BD / 2) obs[i / BD] = TX;
      if (cmd_sent) begin cs_pos = i; cs_hits++; end
      if (busy !== 1'b1) busy_low++;
      if (poke && i == 40) begin cmd = 16'hFFFF; snd_cmd = 1'b1; end
      if (poke && i == 41) snd_cmd = 1'b0;
      if (i != 20 * BD - 1) @(negedge clk);
    end
    chk("tx_bits", 32'(obs), 32'(expw));
    chk("tx_stable", nmis, 0);
    chk("cmd_sent_pos", cs_pos + 1, 20 * BD);
    chk("cmd_sent_once", cs_hits, 1);
    chk("busy_hold", busy_low, 0);
  endtask

  task automatic send_rx(input logic [7:0] b, input bit stop_ok);
    RX = 1'b0; repeat (BD) @(negedge clk);
    for (int k = 0; k < 8; k++) begin RX = b[k]; repeat (BD) @(negedge clk); end
    RX = stop_ok; repeat (BD) @(negedge clk);
    RX = 1'b1; repeat (4) @(negedge clk);
  endtask

  initial begin
    logic [15:0] c;
    logic [7:0]  x;
    logic [7:0]  expq[$];
    int n, fe0, tx_low, w;

    // ---- reset state ----
    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(TX), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_cmd_sent", 32'(cmd_sent), 0);
    chk("rst_resp_rdy", 32'(resp_rdy), 0);
    chk("rst_frm_err", 32'(frm_err), 0);
    chk("rst_timeout", 32'(timeout), 0);
    chk("rst_resp", 32'(resp), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // ---- directed: 0x2004, then 0x5A / 0xA5 ----
    do_cmd(16'h2004, 1'b0);
    rq.delete();
    @(negedge clk);
    chk("wait_busy", 32'(busy), 1);
    send_rx(RESP_PROG, 1'b1);
    chk("prog_busy", 32'(busy), 1);
    send_rx(RESP_DONE, 1'b1);
    chk("resp_cnt", rq.size(), 2);
    if (rq.size() == 2) begin
      chk("resp0", 32'(rq[0]), 32'h5A);
      chk("resp1", 32'(rq[1]), 32'hA5);
    end
    chk("done_busy", 32'(busy), 0);
    chk("a5_busy_edge", {a5_prev, a5_busy}, 2'b10);

    // ---- snd_cmd while busy, framing error, glitch ----
    c = 16'($urandom);
    do_cmd(c, 1'b1);
    rq.delete();
    x = 8'($urandom);
    if (x == RESP_DONE) x = 8'h3C;
    send_rx(x, 1'b1);
    fe0 = fe_n;
    send_rx(RESP_DONE, 1'b0);
    chk("frm_err_cnt", fe_n - fe0, 1);
    chk("frm_resp_hold", 32'(resp), 32'(x));
    chk("frm_busy", 32'(busy), 1);
    RX = 1'b0; repeat (5) @(negedge clk);
    RX = 1'b1; repeat (40) @(negedge clk);
    chk("glitch_no_byte", rq.size(), 1);
    chk("glitch_frm", fe_n - fe0, 1);
    send_rx(RESP_DONE, 1'b1);
    chk("poke_busy", 32'(busy), 0);
    tx_low = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (TX !== 1'b1) tx_low++;
    end
    chk("no_second_tx", tx_low, 0);

    // ---- randomized commands and responses ----
    for (int t = 0; t < 4; t++) begin
      c = 16'($urandom);
      do_cmd(c, 1'($urandom_range(0, 1)));
      rq.delete(); expq.delete();
      n = $urandom_range(0, 2);
      for (int j = 0; j < n; j++) begin
        x = ($urandom_range(0, 1) == 1) ? RESP_PROG : 8'($urandom);
        if (x == RESP_DONE) x = RESP_PROG;
        expq.push_back(x);
        send_rx(x, 1'b1);
      end
      chk("rnd_busy_mid", 32'(busy), 1);
      expq.push_back(RESP_DONE);
      send_rx(RESP_DONE, 1'b1);
      chk("rnd_resp_cnt", rq.size(), expq.size());
      for (int j = 0; j < expq.size() && j < rq.size(); j++)
        chk("rnd_resp", 32'(rq[j]), 32'(expq[j]));
      chk("rnd_busy_done", 32'(busy), 0);
      repeat (3) @(negedge clk);
    end

    // ---- no response: timeout or indefinite wait ----
    to_n = 0;
    do_cmd(16'($urandom), 1'b0);
`ifdef REMOTE_TIMEOUT_EN
    w = 0;
    while (to_n == 0 && w < TO + 100) begin @(negedge clk); w++; end
    chk("to_seen", to_n, 1);
    chk("to_delay", to_cyc - cs_cyc, TO);
    chk("to_busy", 32'(busy), 0);
    repeat (5) @(negedge clk);
`else
    repeat (5000) @(negedge clk);
    chk("noto_busy", 32'(busy), 1);
    chk("noto_pulse", to_n, 0);
    send_rx(RESP_DONE, 1'b1);
    chk("noto_done", 32'(busy), 0);
`endif

    // ---- reset mid high byte ----
    cmd = 16'($urandom); snd_cmd = 1'b1;
    @(negedge clk);
    snd_cmd = 1'b0;
    repeat (50) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_tx", 32'(TX), 1);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_resp", 32'(resp), 0);
    @(negedge clk);
    do_cmd(16'($urandom), 1'b0);
    send_rx(RESP_DONE, 1'b1);
    chk("midrst_done", 32'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
